// File: rtl/bcd_pkg.sv
// Shared BCD helpers for the counter/timer blocks: digit width, digit limit,
// vector validity check and single-digit increment/decrement with carry/borrow.
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam int BCD_VEC_W = 64;

  typedef struct packed {
    logic       flag;
    logic [3:0] digit;
  } bcd_step_t;

  // Callers zero-extend narrower vectors; zero nibbles are valid BCD.
  function automatic logic bcd_valid(input logic [BCD_VEC_W-1:0] vec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_VEC_W / BCD_W; i++) begin
      if (vec[i*BCD_W +: BCD_W] > BCD_MAX_DIGIT) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic bcd_step_t bcd_incr(input logic [3:0] d);
    bcd_step_t r;
    if (d >= BCD_MAX_DIGIT) begin
      r.flag  = 1'b1;
      r.digit = 4'd0;
    end else begin
      r.flag  = 1'b0;
      r.digit = d + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_step_t bcd_decr(input logic [3:0] d);
    bcd_step_t r;
    if (d == 4'd0) begin
      r.flag  = 1'b1;
      r.digit = BCD_MAX_DIGIT;
    end else begin
      r.flag  = 1'b0;
      r.digit = d - 4'd1;
    end
    return r;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick when the count reaches PRESCALE-1.
// Only clr or reset restart it.
module tick_gen #(
  parameter int PRESCALE   = 25_000_000,
  parameter int PRESCALE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + PRESCALE_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with wrap/saturate, load/clear and
// terminal-count pulse, stepped by an internal prescaler tick.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int                  DIGITS     = 2,
  parameter logic [4*DIGITS-1:0] MAX_VAL    = {DIGITS{4'h9}},
  parameter int                  PRESCALE   = 25_000_000,
  parameter int                  PRESCALE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic                up,
  input  logic                sat_mode,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tick_o,
  output logic                tc,
  output logic                load_err
);
  localparam int CW = BCD_W * DIGITS;

  logic [CW-1:0]        count_q, count_d, inc_val, dec_val;
  logic                 tc_q, tc_d, lerr_q, lerr_d;
  logic                 tick, step, at_max, at_zero, load_ok;
  logic [DIGITS:0]      carry, borrow;
  logic [BCD_VEC_W-1:0] load_pad;
  logic                 chain_unused;

  tick_gen #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  // Ripple chain: digit i changes only when every lower digit rolled over.
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      bcd_step_t inc_r, dec_r;
      assign inc_r = bcd_incr(count_q[i*BCD_W +: BCD_W]);
      assign dec_r = bcd_decr(count_q[i*BCD_W +: BCD_W]);
      assign inc_val[i*BCD_W +: BCD_W] = carry[i]  ? inc_r.digit : count_q[i*BCD_W +: BCD_W];
      assign dec_val[i*BCD_W +: BCD_W] = borrow[i] ? dec_r.digit : count_q[i*BCD_W +: BCD_W];
      assign carry[i+1]  = carry[i]  & inc_r.flag;
      assign borrow[i+1] = borrow[i] & dec_r.flag;
    end
  endgenerate

  // Limits are detected explicitly, so the top-digit carry/borrow is not needed.
  assign chain_unused = carry[DIGITS] ^ borrow[DIGITS];

  assign load_pad = BCD_VEC_W'(load_val);
  assign load_ok  = bcd_valid(load_pad) && (load_val <= MAX_VAL);
  assign at_max   = (count_q == MAX_VAL);
  assign at_zero  = (count_q == '0);
  assign step     = tick & en;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    lerr_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) count_d = load_val;
      else         lerr_d  = 1'b1;
    end else if (step) begin
      if (up) begin
        if (at_max) begin
          tc_d = 1'b1;
          if (!sat_mode) count_d = '0;
        end else begin
          count_d = inc_val;
        end
      end else begin
        if (at_zero) begin
          tc_d = 1'b1;
          if (!sat_mode) count_d = MAX_VAL;
        end else begin
          count_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count    = count_q;
  assign tick_o   = tick;
  assign tc       = tc_q;
  assign load_err = lerr_q;
endmodule
